// File: rtl/aes_decrypt.sv
// rtl/aes_decrypt.sv - AES-128 inverse cipher, one round per cycle after an on-the-fly
// ten-cycle key expansion.
module aes_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic [127:0] ciphertext_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] rk [0:10];
  logic [127:0] ct_q;
  logic [127:0] st_q;
  logic [3:0]   kcnt;
  logic [3:0]   rcnt;
  logic [127:0] rk_new;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Words hold FIPS byte 0 in their low byte, so RotWord moves the low byte to the top.
  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    t  = {sbox(k[103:96]), sbox(k[127:120]), sbox(k[119:112]), sbox(k[111:104]) ^ rc};
    w0 = k[31:0] ^ t;
    w1 = k[63:32] ^ w0;
    w2 = k[95:64] ^ w1;
    w3 = k[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[31:24],   s[55:48],  s[79:72],   s[103:96],
            s[127:120], s[23:16],  s[47:40],   s[71:64],
            s[95:88],   s[119:112], s[15:8],   s[39:32],
            s[63:56],   s[87:80],  s[111:104], s[7:0]};
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    return {inv_sub_word(s[127:96]), inv_sub_word(s[95:64]),
            inv_sub_word(s[63:32]), inv_sub_word(s[31:0])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [0:3];
    logic [7:0] m9 [0:3];
    logic [7:0] mb [0:3];
    logic [7:0] md [0:3];
    logic [7:0] me [0:3];
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    a[0] = c[7:0];
    a[1] = c[15:8];
    a[2] = c[23:16];
    a[3] = c[31:24];
    for (int i = 0; i < 4; i++) begin
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            me[0] ^ mb[1] ^ md[2] ^ m9[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  always_comb begin
    rk_new    = next_rk(rk[kcnt - 4'd1], rcon(kcnt));
    round_out = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk[rcnt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = KEXP;
      end
      KEXP: begin
        busy = 1'b1;
        if (kcnt == 4'd10) state_next = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (rcnt == 4'd0) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) rk[i] <= '0;
      ct_q          <= '0;
      st_q          <= '0;
      kcnt          <= '0;
      rcnt          <= '0;
      plaintext_out <= '0;
      out_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rk[0] <= key_in;
            ct_q  <= ciphertext_in;
            kcnt  <= 4'd1;
          end
        end
        KEXP: begin
          rk[kcnt] <= rk_new;
          if (kcnt == 4'd10) begin
            st_q <= ct_q ^ rk_new;
            rcnt <= 4'd9;
          end else begin
            kcnt <= kcnt + 4'd1;
          end
        end
        ROUND: begin
          if (rcnt != 4'd0) begin
            st_q <= inv_mix_columns(round_out);
            rcnt <= rcnt - 4'd1;
          end else begin
            plaintext_out <= round_out;
            out_valid     <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// tb/tb_aes_decrypt.sv - self-checking bench for aes_decrypt against a byte-level AES-128
// encryption model (round trip) and the FIPS-197 vectors.
module tb_aes_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key_in;
  logic [127:0] ciphertext_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext_out;
  logic         busy;

  localparam logic [127:0] C1_KEY = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] C1_CT  = 128'h5AC5B47080B7CDD830047B6AD8E0C469;
  localparam logic [127:0] C1_PT  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] B_KEY  = 128'h3C4FCF098815F7ABA6D2AE2816157E2B;
  localparam logic [127:0] B_CT   = 128'h320B6A19978511DCFB09DC021D842539;
  localparam logic [127:0] B_PT   = 128'h340737E0A29831318D305A88A8F64332;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sbox_t [0:255];

  always #5 clk = ~clk;

  aes_decrypt dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .key_in        (key_in),
    .ciphertext_in (ciphertext_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .plaintext_out (plaintext_out),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ mul2(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   w [0:175];
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   tmp [0:3];
    logic [7:0]   a0, a1, a2, a3;
    logic [7:0]   rc;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) w[i] = key[8*i +: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*i-4+j];
      if (i % 4 == 0) begin
        tmp[0] = sbox_t[w[4*i-3]] ^ rc;
        tmp[1] = sbox_t[w[4*i-2]];
        tmp[2] = sbox_t[w[4*i-1]];
        tmp[3] = sbox_t[w[4*i-4]];
        rc = mul2(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = sbox_t[s[4*((c+rr)%4)+rr]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
          s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Returns at #1 after the accept edge, with the data inputs scrambled.
  task automatic submit(input logic [127:0] k, input logic [127:0] c);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("submit_ready", in_ready, 1);
    in_valid      = 1'b1;
    key_in        = k;
    ciphertext_in = c;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    key_in        = rand128();
    ciphertext_in = rand128();
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!out_valid && edges < 40);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, out_valid, 0);
    check({tag, "_hs_ready"}, in_ready, 1);
  endtask

  task automatic finish_job(input string tag, input logic [127:0] exp_pt, input int exp_lat);
    int e;
    wait_done(e);
    check({tag, "_lat"}, e, exp_lat);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_pt"}, plaintext_out, exp_pt);
    handshake(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;
    logic [127:0] k;
    logic [127:0] p;
    rst           = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    key_in        = '0;
    ciphertext_in = '0;
    build_sbox();
    #2 rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pt", plaintext_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    submit(C1_KEY, C1_CT);
    check("c1_busy_kexp", busy, 1);
    check("c1_ready_kexp", in_ready, 0);
    finish_job("c1", C1_PT, 20);

    submit(B_KEY, B_CT);
    wait_done(e);
    check("b_lat", e, 20);
    check("b_valid", out_valid, 1);
    check("b_pt", plaintext_out, B_PT);
    for (int i = 0; i < 15; i++) begin
      in_valid      = 1'($urandom_range(0, 1));
      key_in        = rand128();
      ciphertext_in = rand128();
      @(posedge clk);
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_pt", plaintext_out, B_PT);
      check("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_pt_retained", plaintext_out, B_PT);

    submit(C1_KEY, C1_CT);
    repeat (14) @(posedge clk);
    #1;
    check("mr_busy_round", busy, 1);
    rst = 1'b1;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_pt", plaintext_out, 0);
    check("mr_busy", busy, 0);
    check("mr_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    submit(C1_KEY, C1_CT);
    finish_job("mr_c1", C1_PT, 20);

    submit(C1_KEY, C1_CT);
    in_valid      = 1'b1;
    key_in        = B_KEY;
    ciphertext_in = B_CT;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("ign_busy", busy, 1);
    end
    in_valid = 1'b0;
    finish_job("ign_c1", C1_PT, 15);
    repeat (25) @(posedge clk);
    #1;
    check("ign_no_job_valid", out_valid, 0);
    check("ign_no_job_busy", busy, 0);

    for (int n = 0; n < 100; n++) begin
      k = rand128();
      p = rand128();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      submit(k, aes_enc(k, p));
      finish_job("rt", p, 20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 The module SHALL have no parameters; the algorithm is fixed to AES-128 (FIPS-197 inverse cipher).
REQ-002 The port `clk` SHALL be a 1-bit input: the single clock; all state updates on its rising edge.
REQ-003 The port `rst` SHALL be a 1-bit input: reset, asynchronous and active-high.
REQ-004 The port `in_valid` SHALL be a 1-bit input: `key_in` and `ciphertext_in` are valid.
REQ-005 The port `in_ready` SHALL be a 1-bit output: the block can accept a new job.
REQ-006 The port `key_in` SHALL be a 128-bit input: the cipher key.
REQ-007 The port `ciphertext_in` SHALL be a 128-bit input: the block to decrypt.
REQ-008 The port `out_valid` SHALL be a 1-bit output: `plaintext_out` holds a completed result.
REQ-009 The port `out_ready` SHALL be a 1-bit input: the consumer takes the result.
REQ-010 The port `plaintext_out` SHALL be a 128-bit output: the decrypted block.
REQ-011 The port `busy` SHALL be a 1-bit output: high when the state is KEXP or ROUND.
REQ-012 All 128-bit buses SHALL use little-endian byte packing: FIPS byte i occupies bits [8i+7:8i]. This matches the `aes` encryptor, so a ciphertext from `aes` SHALL decrypt unchanged.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, KEXP, ROUND and DONE.
REQ-014 `in_ready` SHALL be 1 only in IDLE. A job SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
- On accept, `key_in` and `ciphertext_in` SHALL be registered.
- Later changes on those inputs SHALL have no effect on the job in flight.
REQ-015 On accept, the FSM SHALL move IDLE->KEXP and load the round-key counter to 1.
REQ-016 KEXP SHALL last exactly 10 cycles. Each cycle computes round key rk[n] from rk[n-1]:
- RotWord, SubWord and Rcon (01,02,04,08,10,20,40,80,1B,36), per FIPS-197 key expansion;
- rk0 is the registered key;
- rk0..rk10 are stored in an 11-entry register array.
REQ-017 On the 10th KEXP edge, the FSM SHALL move to ROUND, load the state register with ct ^ rk10, and load the round counter to 9.
REQ-018 For rounds 9..1, each ROUND cycle SHALL compute, in order: InvShiftRows, InvSubBytes, AddRoundKey(rk[r]), InvMixColumns. The round counter then decrements.
REQ-019 Round 0 SHALL compute InvShiftRows, InvSubBytes and AddRoundKey(rk0), with no InvMixColumns.
- The result SHALL be written to `plaintext_out`.
- out_valid SHALL be set to 1.
- The FSM SHALL move to DONE.
REQ-020 Latency SHALL be fixed: out_valid rises exactly 20 rising edges after the accept edge, regardless of data.
REQ-021 In DONE, out_valid and plaintext_out SHALL hold stable while out_ready=0, for any duration.
REQ-022 In DONE, on an edge with out_ready=1, the block SHALL clear out_valid and return to IDLE. in_ready SHALL rise in the same cycle. No new job is accepted on that same edge.
REQ-023 `plaintext_out` SHALL retain the last result after the handshake until the next completion.
REQ-024 in_valid SHALL be ignored while in_ready=0; no job is queued or lost-state corrupted.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 The inverse S-box, the forward S-box (for key expansion), and xtime-based GF(2^8) multiplies by 09/0B/0D/0E MAY be separate submodules or functions. They SHALL be purely combinational.

Reset
REQ-027 While rst=1, asynchronously:
- the FSM SHALL be IDLE;
- out_valid=0 and busy=0;
- in_ready SHALL be 1 (combinational from IDLE);
- plaintext_out and all counters SHALL be 0;
- the round-key array and state register SHALL be 0.
REQ-028 Reset asserted during KEXP, ROUND or DONE SHALL abort the job with no output.
- After deassertion, the first accepted job SHALL produce the correct result with normal latency.
REQ-029 Reset deassertion SHALL be synchronous-safe: no accept occurs on the edge coinciding with deassertion if rst is still sampled high.

Verification
REQ-030 The bench SHALL cover FIPS C.1 vector:
- stimulus: key_in=0F0E0D0C0B0A09080706050403020100, ciphertext_in=5AC5B47080B7CDD830047B6AD8E0C469;
- required response: plaintext_out=FFEEDDCCBBAA99887766554433221100, out_valid rising exactly 20 edges after accept.
REQ-031 The bench SHALL cover FIPS App. B vector:
- stimulus: key_in=3C4FCF098815F7ABA6D2AE2816157E2B, ciphertext_in=320B6A19978511DCFB09DC021D842539;
- required response: plaintext_out=340737E0A29831318D305A88A8F64332.
REQ-032 The bench SHALL cover backpressure:
- stimulus: hold out_ready=0 for 15 cycles after out_valid; toggle in_valid and the input data meanwhile;
- required response: out_valid=1, plaintext_out unchanged, in_ready=0 throughout; after out_ready=1 for one edge, out_valid=0 and in_ready=1.
REQ-033 The bench SHALL cover mid-job reset:
- stimulus: assert rst for 1 cycle at ROUND counter=5, then submit the REQ-030 vector;
- required response: out_valid=0 and plaintext_out=0 during reset; the correct C.1 result 20 edges after the new accept.
REQ-034 The bench SHALL cover busy-ignore and round trip:
- stimulus: drive in_valid=1 with vector B while the C.1 job is in KEXP;
- required response: only the C.1 result is produced.
- stimulus: feed an `aes` encryptor's ciphertext_out (same key_in) into aes_decrypt;
- required response: the original plaintext_in is recovered, for 100 random key/plaintext pairs.
